// File: rtl/sd_block_responder_if.sv
// Byte-wide backing-store port between the block responder (master) and memory (slave).
interface sd_block_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sd_block_responder.sv
// Serves 512-byte SD block reads/writes for three virtual drives from a byte-wide
// backing store; each drive's image lives at d<<BASE_SHIFT.
module sd_block_responder #(
  parameter int unsigned BASE_SHIFT = 24,
  parameter int unsigned VDNUM      = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [95:0] sd_lba,
  input  logic [2:0]  sd_rd,
  input  logic [2:0]  sd_wr,
  output logic [2:0]  sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  input  logic [23:0] sd_buff_din,
  output logic        sd_buff_wr,
  input  logic        mnt_strobe,
  input  logic [1:0]  mnt_idx,
  input  logic [31:0] mnt_size,
  input  logic        mnt_ro,
  output logic [2:0]  img_mounted,
  output logic [63:0] img_size,
  output logic        img_readonly,
  sd_block_responder_if.master mem
);

  typedef enum logic [2:0] {IDLE, START, RD_REQ, RD_PUT, WR_ADDR, WR_REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d, last_q, last_d;
  logic [2:0]        ack_q, ack_d;
  logic [22:0]       lba_q, lba_d;
  logic              valid_q, valid_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              cap_q, cap_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [7:0]        wdata_q, wdata_d, dout_q, dout_d;
  logic              bwr_q, bwr_d;
  logic [2:0][31:0]  size_q, size_d;
  logic [2:0]        ro_q, ro_d, mnt_q, mnt_d;
  logic [2:0]        img_mnt_q, img_mnt_d;
  logic [31:0]       img_size_q, img_size_d;
  logic              img_ro_q, img_ro_d;

  logic [31:0] lba_sel, size_sel;
  logic [7:0]  din_sel;
  logic        ro_sel, mnt_sel, rd_sel, blk_ok;
  logic [2:0]  req;
  logic [1:0]  rr_cand, rr_pick;
  logic        rr_found;
  logic        last_byte;

  assign req       = sd_rd | sd_wr;
  assign last_byte = (cnt_q == 9'd511);

  always_comb begin
    lba_sel  = '0;
    size_sel = '0;
    din_sel  = '0;
    ro_sel   = 1'b0;
    mnt_sel  = 1'b0;
    rd_sel   = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (32'(sel_q) == i) begin
        lba_sel  = sd_lba[32*i +: 32];
        size_sel = size_q[i];
        din_sel  = sd_buff_din[8*i +: 8];
        ro_sel   = ro_q[i];
        mnt_sel  = mnt_q[i];
        rd_sel   = sd_rd[i];
      end
    end
    // Last byte address of the block must lie inside the image; 41 bits so nothing wraps.
    blk_ok = mnt_sel && ({lba_sel, 9'h1FF} < {9'd0, size_sel});
  end

  always_comb begin
    rr_cand  = '0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= VDNUM; k++) begin
      rr_cand = 2'((32'(last_q) + k) % VDNUM);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    ack_d      = ack_q;
    lba_d      = lba_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    bwr_d      = 1'b0;
    size_d     = size_q;
    ro_d       = ro_q;
    mnt_d      = mnt_q;
    img_mnt_d  = '0;
    img_size_d = img_size_q;
    img_ro_d   = img_ro_q;

    for (int unsigned i = 0; i < 3; i++) begin
      if (mnt_strobe && (32'(mnt_idx) == i)) begin
        size_d[i]    = mnt_size;
        ro_d[i]      = mnt_ro;
        mnt_d[i]     = 1'b1;
        img_mnt_d[i] = 1'b1;
        img_size_d   = mnt_size;
        img_ro_d     = mnt_ro;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          sel_d   = rr_pick;
          last_d  = rr_pick;
          state_d = START;
        end
      end
      START: begin
        ack_d   = 3'b001 << sel_q;
        lba_d   = lba_sel[22:0];
        cnt_d   = '0;
        cap_d   = 1'b0;
        // Read-only is folded into the write validity flag.
        if (rd_sel) begin
          valid_d   = blk_ok;
          mem_req_d = blk_ok;
          mem_we_d  = 1'b0;
          state_d   = RD_REQ;
        end else begin
          valid_d = blk_ok && !ro_sel;
          state_d = WR_ADDR;
        end
      end
      RD_REQ: begin
        if (!valid_q) begin
          dout_d  = 8'h00;
          bwr_d   = 1'b1;
          state_d = RD_PUT;
        end else if (mem_req_q && mem.mem_ack) begin
          mem_req_d = 1'b0;
          dout_d    = mem.mem_rdata;
          bwr_d     = 1'b1;
          state_d   = RD_PUT;
        end
      end
      RD_PUT: begin
        if (last_byte) begin
          ack_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d     = cnt_q + 9'd1;
          mem_req_d = valid_q;
          state_d   = RD_REQ;
        end
      end
      WR_ADDR: begin
        cap_d   = 1'b1;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (cap_q) begin
          cap_d   = 1'b0;
          wdata_d = din_sel;
          if (valid_q) begin
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
          end else if (last_byte) begin
            ack_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 9'd1;
            state_d = WR_ADDR;
          end
        end else if (mem_req_q && mem.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (last_byte) begin
            ack_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 9'd1;
            state_d = WR_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= 2'd2;
      ack_q      <= '0;
      lba_q      <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      wdata_q    <= '0;
      dout_q     <= '0;
      bwr_q      <= 1'b0;
      size_q     <= '0;
      ro_q       <= '0;
      mnt_q      <= '0;
      img_mnt_q  <= '0;
      img_size_q <= '0;
      img_ro_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      lba_q      <= lba_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      bwr_q      <= bwr_d;
      size_q     <= size_d;
      ro_q       <= ro_d;
      mnt_q      <= mnt_d;
      img_mnt_q  <= img_mnt_d;
      img_size_q <= img_size_d;
      img_ro_q   <= img_ro_d;
    end
  end

  assign sd_ack         = ack_q;
  assign sd_buff_addr   = cnt_q;
  assign sd_buff_dout   = dout_q;
  assign sd_buff_wr     = bwr_q;
  assign img_mounted    = img_mnt_q;
  assign img_size       = {32'd0, img_size_q};
  assign img_readonly   = img_ro_q;
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_addr   = (32'(sel_q) << BASE_SHIFT) + {lba_q, cnt_q};

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: a byte memory that acks every other cycle,
// a one-cycle-latency buffer RAM model, and a negedge monitor logging traffic.
module tb_sd_block_responder;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [95:0] sd_lba;
  logic [2:0]  sd_rd, sd_wr;
  logic [2:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [23:0] sd_buff_din;
  logic        sd_buff_wr;
  logic        mnt_strobe;
  logic [1:0]  mnt_idx;
  logic [31:0] mnt_size;
  logic        mnt_ro;
  logic [2:0]  img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;

  sd_block_responder_if mem_bus ();

  sd_block_responder #(.BASE_SHIFT(24), .VDNUM(3)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .mnt_strobe   (mnt_strobe),
    .mnt_idx      (mnt_idx),
    .mnt_size     (mnt_size),
    .mnt_ro       (mnt_ro),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .mem          (mem_bus)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Traffic logs
  int unsigned cyc = 0;
  int unsigned strobe_cnt, mem_cnt, req_cycles, we_cycles;
  logic [8:0]  strobe_addr [512];
  logic [7:0]  strobe_data [512];
  int unsigned strobe_cyc  [512];
  logic [31:0] mem_addr_log [512];
  logic [7:0]  mem_data_log [512];
  logic        multi_ack;
  logic [2:0]  prev_ack;
  logic [2:0]  ack_seq [$];

  // Memory: acks every request one cycle later, read data = addr[7:0].
  // Buffer RAM: din follows the address sampled at the previous edge, inverted.
  initial begin
    logic [8:0] a;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    sd_buff_din       = '0;
    forever begin
      @(posedge clk_sys);
      a = sd_buff_addr;
      #1;
      sd_buff_din = {3{~a[7:0]}};
      if (mem_bus.mem_req && !mem_bus.mem_ack) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = mem_bus.mem_addr[7:0];
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
    end
  end

  initial begin
    prev_ack = '0;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (sd_buff_wr) begin
        if (strobe_cnt < 512) begin
          strobe_addr[strobe_cnt] = sd_buff_addr;
          strobe_data[strobe_cnt] = sd_buff_dout;
          strobe_cyc[strobe_cnt]  = cyc;
        end
        strobe_cnt++;
      end
      if (mem_bus.mem_req) req_cycles++;
      if (mem_bus.mem_req && mem_bus.mem_we) we_cycles++;
      if (mem_bus.mem_req && mem_bus.mem_ack) begin
        if (mem_cnt < 512) begin
          mem_addr_log[mem_cnt] = mem_bus.mem_addr;
          mem_data_log[mem_cnt] = mem_bus.mem_wdata;
        end
        mem_cnt++;
      end
      if ($countones(sd_ack) > 1) multi_ack = 1'b1;
      if (sd_ack != 3'b000 && sd_ack != prev_ack) ack_seq.push_back(sd_ack);
      prev_ack = sd_ack;
    end
  end

  task automatic clear_logs();
    strobe_cnt = 0; mem_cnt = 0; req_cycles = 0; we_cycles = 0;
    multi_ack = 1'b0;
    ack_seq.delete();
  endtask

  task automatic mount(input logic [1:0] idx, input logic [31:0] size, input logic ro);
    @(negedge clk_sys);
    mnt_strobe = 1'b1; mnt_idx = idx; mnt_size = size; mnt_ro = ro;
    @(negedge clk_sys);
    mnt_strobe = 1'b0;
  endtask

  // Raise a request, drop it once acked, return when ack falls. ncyc counts edges
  // from the request; ack_at is the edge count at which ack was first seen high.
  task automatic run_xfer(input int unsigned d, input logic rd, output logic to,
                          output int unsigned ncyc, output int unsigned ack_at);
    logic seen;
    @(negedge clk_sys);
    if (rd) sd_rd[d] = 1'b1; else sd_wr[d] = 1'b1;
    seen = 1'b0; to = 1'b1; ncyc = 0; ack_at = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk_sys);
      ncyc++;
      @(negedge clk_sys);
      if (sd_ack[d]) begin
        if (!seen) ack_at = ncyc;
        seen = 1'b1;
        sd_rd[d] = 1'b0;
        sd_wr[d] = 1'b0;
      end else if (seen) begin
        to = 1'b0;
        break;
      end
    end
    sd_rd[d] = 1'b0;
    sd_wr[d] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    sd_lba = '0; sd_rd = '0; sd_wr = '0;
    mnt_strobe = 1'b0; mnt_idx = '0; mnt_size = '0; mnt_ro = 1'b0;
    apply_reset();
    checks++;
    if ({sd_ack, sd_buff_wr, sd_buff_dout} !== 12'd0) begin
      failures++; $display("FAIL reset_sd outputs: ack=%b wr=%b dout=%h, need 0", sd_ack, sd_buff_wr, sd_buff_dout);
    end
    checks++;
    if (sd_buff_addr !== 9'd0) begin
      failures++; $display("FAIL reset_buff_addr: got %0d need 0", sd_buff_addr);
    end
    checks++;
    if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wdata} !== 10'd0) begin
      failures++; $display("FAIL reset_mem ctl: req=%b we=%b wdata=%h need 0", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wdata);
    end
    checks++;
    if (mem_bus.mem_addr !== 32'd0) begin
      failures++; $display("FAIL reset_mem_addr: got %h need 0", mem_bus.mem_addr);
    end
    checks++;
    if ({img_mounted, img_size, img_readonly} !== 68'd0) begin
      failures++; $display("FAIL reset_img: mnt=%b size=%0d ro=%b need 0", img_mounted, img_size, img_readonly);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_mount();
    mount(2'd0, 32'd143360, 1'b0);
    checks++;
    if (img_mounted !== 3'b001 || img_size !== 64'd143360 || img_readonly !== 1'b0) begin
      failures++; $display("FAIL mount_report: mnt=%b size=%0d ro=%b need 001/143360/0", img_mounted, img_size, img_readonly);
    end
    @(negedge clk_sys);
    checks++;
    if (img_mounted !== 3'b000) begin
      failures++; $display("FAIL mount_pulse_width: got %b need 000", img_mounted);
    end
    mount(2'd3, 32'd999, 1'b1);
    checks++;
    if (img_mounted !== 3'b000 || img_size !== 64'd143360) begin
      failures++; $display("FAIL mount_idx3_ignored: mnt=%b size=%0d need 000/143360", img_mounted, img_size);
    end
  endtask

  task automatic test_read();
    logic to; int unsigned n, at, bad;
    clear_logs();
    sd_lba = {64'd0, 32'd2};
    run_xfer(0, 1'b1, to, n, at);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL read_timeout: ack never completed"); end
    checks++;
    if (at != 2) begin failures++; $display("FAIL read_ack_latency: got %0d need 2", at); end
    checks++;
    if (strobe_cnt != 512) begin failures++; $display("FAIL read_strobes: got %0d need 512", strobe_cnt); end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (strobe_addr[i] !== 9'(i) || strobe_data[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL read_strobe_content: %0d bad, need 0", bad); end
    checks++;
    if (mem_cnt != 512 || we_cycles != 0) begin
      failures++; $display("FAIL read_mem_txn: txns=%0d we=%0d need 512/0", mem_cnt, we_cycles);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem_addr_log[i] !== 32'h400 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL read_mem_addr: %0d bad, first %h need 400", bad, mem_addr_log[0]); end
  endtask

  task automatic test_write();
    logic to; int unsigned n, at, bad;
    mount(2'd1, 32'd4096, 1'b0);
    clear_logs();
    sd_lba = {32'd0, 32'd3, 32'd0};
    run_xfer(1, 1'b0, to, n, at);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL write_timeout: ack never completed"); end
    checks++;
    if (mem_cnt != 512 || we_cycles != 512) begin
      failures++; $display("FAIL write_mem_txn: txns=%0d we=%0d need 512/512", mem_cnt, we_cycles);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem_addr_log[i] !== 32'h0100_0600 + 32'(i) || mem_data_log[i] !== ~8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL write_mem_content: %0d bad, first %h/%h need 01000600/ff", bad, mem_addr_log[0], mem_data_log[0]);
    end
    checks++;
    if (strobe_cnt != 0) begin failures++; $display("FAIL write_no_strobe: got %0d need 0", strobe_cnt); end
  endtask

  task automatic test_back_to_back();
    logic to;
    apply_reset();
    reset_n = 1'b1;
    mount(2'd0, 32'd143360, 1'b0);
    mount(2'd2, 32'd143360, 1'b0);
    clear_logs();
    @(negedge clk_sys);
    sd_lba = '0;
    sd_rd  = 3'b101;
    to = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk_sys);
      if (sd_ack[0]) sd_rd[0] = 1'b0;
      if (sd_ack[2]) sd_rd[2] = 1'b0;
      if (sd_rd == 3'b000 && sd_ack == 3'b000) begin to = 1'b0; break; end
    end
    sd_rd = '0;
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL rr_timeout: transfers did not finish"); end
    checks++;
    if (ack_seq.size() != 2 || ack_seq[0] !== 3'b001 || ack_seq[1] !== 3'b100) begin
      failures++; $display("FAIL rr_order: n=%0d first=%b second=%b need 2/001/100", ack_seq.size(), ack_seq[0], ack_seq[1]);
    end
    checks++;
    if (multi_ack !== 1'b0) begin failures++; $display("FAIL rr_single_ack: got multi=%b need 0", multi_ack); end
    checks++;
    if (strobe_cnt != 1024) begin failures++; $display("FAIL rr_strobes: got %0d need 1024", strobe_cnt); end
  endtask

  task automatic test_invalid_read();
    logic to; int unsigned n, at, bad;
    clear_logs();
    sd_lba = {64'd0, 32'd280};
    run_xfer(0, 1'b1, to, n, at);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL inv_timeout: ack never completed"); end
    checks++;
    if (strobe_cnt != 512) begin failures++; $display("FAIL inv_strobes: got %0d need 512", strobe_cnt); end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (strobe_data[i] !== 8'h00 || strobe_addr[i] !== 9'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL inv_strobe_content: %0d bad, need 0", bad); end
    checks++;
    if (req_cycles != 0) begin failures++; $display("FAIL inv_no_mem_req: got %0d need 0", req_cycles); end
    checks++;
    if (strobe_cyc[511] - strobe_cyc[0] != 1022) begin
      failures++; $display("FAIL inv_strobe_rate: span %0d need 1022", strobe_cyc[511] - strobe_cyc[0]);
    end
  endtask

  task automatic test_readonly_write();
    logic to; int unsigned n, at;
    mount(2'd2, 32'd143360, 1'b1);
    checks++;
    if (img_mounted !== 3'b100 || img_readonly !== 1'b1) begin
      failures++; $display("FAIL ro_mount_report: mnt=%b ro=%b need 100/1", img_mounted, img_readonly);
    end
    clear_logs();
    sd_lba = '0;
    run_xfer(2, 1'b0, to, n, at);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL ro_timeout: ack never completed"); end
    checks++;
    if (n != 1026) begin failures++; $display("FAIL ro_duration: got %0d need 1026", n); end
    checks++;
    if (we_cycles != 0 || req_cycles != 0) begin
      failures++; $display("FAIL ro_no_mem: we=%0d req=%0d need 0/0", we_cycles, req_cycles);
    end
  endtask

  task automatic test_reset_mid();
    logic to; int unsigned n, at;
    mount(2'd0, 32'd143360, 1'b0);
    clear_logs();
    sd_lba = {64'd0, 32'd2};
    @(negedge clk_sys);
    sd_rd[0] = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (sd_ack[0]) sd_rd[0] = 1'b0;
      if (strobe_cnt >= 101) begin to = 1'b0; break; end
    end
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL mid_reach_byte100: strobes=%0d need 101", strobe_cnt); end
    reset_n = 1'b0;
    sd_rd   = '0;
    @(posedge clk_sys);
    #1;
    checks++;
    if (sd_ack !== 3'b000 || mem_bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL mid_reset_drop: ack=%b req=%b need 000/0", sd_ack, mem_bus.mem_req);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    mount(2'd0, 32'd143360, 1'b0);
    clear_logs();
    run_xfer(0, 1'b1, to, n, at);
    checks++;
    if (to !== 1'b0 || strobe_cnt != 512) begin
      failures++; $display("FAIL mid_restart: timeout=%b strobes=%0d need 0/512", to, strobe_cnt);
    end
    checks++;
    if (strobe_addr[0] !== 9'd0 || strobe_data[0] !== 8'h00) begin
      failures++; $display("FAIL mid_restart_first: addr=%0d data=%h need 0/00", strobe_addr[0], strobe_data[0]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_logs();
    test_reset();
    test_mount();
    test_read();
    test_write();
    test_back_to_back();
    test_invalid_read();
    test_readonly_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
